// File: rtl/dac_sample_arbiter.sv
// Paced two-requester sample scheduler feeding a single DAC input.
// A programmable divider defines update slots; in each slot at most one
// requester sample is accepted via valid/ready and registered onto dac_d.
module dac_sample_arbiter #(
    parameter int               WIDTH      = 10,
    parameter int               DIV_W      = 8,
    parameter logic [WIDTH-1:0] RESET_CODE = 10'h200
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] dac_d,
    output logic             dac_upd,
    output logic             grant_id,
    output logic [7:0]       underrun_cnt
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] dac_d_q, dac_d_d;
    logic             dac_upd_q, dac_upd_d;
    logic             grant_id_q, grant_id_d;
    logic [7:0]       underrun_q, underrun_d;

    logic slot;
    logic win0;
    logic win1;
    logic xfer;

    // Slot detection and arbitration; div is compared live against the counter.
    always_comb begin
        slot = enable && (cnt_q >= div);
        win0 = 1'b0;
        win1 = 1'b0;
        if (req0_valid && req1_valid) begin
            // Fixed priority favours requester 0; round-robin favours whoever did not go last.
            if (mode || last_grant_q) begin
                win0 = 1'b1;
            end else begin
                win1 = 1'b1;
            end
        end else begin
            win0 = req0_valid;
            win1 = req1_valid;
        end
    end

    // Ready only inside a slot and never while reset is asserted.
    assign req0_ready = reset & slot & win0;
    assign req1_ready = reset & slot & win1;
    assign xfer       = req0_ready | req1_ready;

    // Next-state for slot counter, DAC register, grant tracking and underrun count.
    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        dac_d_d      = dac_d_q;
        dac_upd_d    = 1'b0;
        grant_id_d   = grant_id_q;
        underrun_d   = underrun_q;

        if (!enable || slot) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (xfer) begin
            dac_d_d      = win1 ? req1_data : req0_data;
            dac_upd_d    = 1'b1;
            grant_id_d   = win1;
            last_grant_d = win1;
        end else if (slot && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset; last_grant starts at 1 so requester 0 wins the first conflict.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            dac_d_q      <= RESET_CODE;
            dac_upd_q    <= 1'b0;
            grant_id_q   <= 1'b0;
            underrun_q   <= 8'd0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            dac_d_q      <= dac_d_d;
            dac_upd_q    <= dac_upd_d;
            grant_id_q   <= grant_id_d;
            underrun_q   <= underrun_d;
        end
    end

    assign dac_d        = dac_d_q;
    assign dac_upd      = dac_upd_q;
    assign grant_id     = grant_id_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: doc/dac_sample_arbiter.md
Name: dac_sample_arbiter

Overview:
- Paced sample scheduler for the 10-bit DAC datapath. Shares the single DAC input between two requesters: requester 0 is the RISC-V core output, requester 1 is an auxiliary source such as a waveform generator.
- A programmable divider on the PLL-derived CLK sets the DAC update rate. On each update slot the block arbitrates, accepts at most one sample through a valid/ready handshake and registers it onto the DAC data bus.
- Tracks slots where no sample was offered (underruns).

Parameters:
- WIDTH, 10, sample/DAC code width.
- DIV_W, 8, width of the rate divider.
- RESET_CODE, 10'h200, DAC code driven after reset (midscale).

Ports:
- CLK  input  1  system clock (PLL output).
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising CLK).
- enable  input  1  1 = slot generation running.
- div  input  DIV_W  slot period minus 1 (period = div+1 cycles).
- mode  input  1  0 = round-robin, 1 = fixed priority to requester 0.
- req0_valid  input  1  requester 0 has a sample.
- req0_data  input  WIDTH  requester 0 sample.
- req0_ready  output  1  requester 0 sample accepted this cycle.
- req1_valid  input  1  requester 1 has a sample.
- req1_data  input  WIDTH  requester 1 sample.
- req1_ready  output  1  requester 1 sample accepted this cycle.
- dac_d  output  WIDTH  registered code to DAC D input.
- dac_upd  output  1  one-cycle pulse: dac_d changed source sample this cycle.
- grant_id  output  1  requester whose sample is on dac_d.
- underrun_cnt  output  8  saturating count of empty slots.

Behaviour:
- Reset (reset=0 at an edge): dac_d=RESET_CODE, dac_upd=0, grant_id=0, underrun_cnt=0, slot counter cnt=0, last_grant=1 (so requester 0 wins the first conflict). req0_ready and req1_ready are held 0 while reset=0. Reset mid-handshake discards any pending transfer.
- Slot counter:
  - enable=0: cnt forced to 0; no slot; all outputs hold except dac_upd=0.
  - enable=1: slot = (cnt >= div). On a slot, cnt<=0; otherwise cnt<=cnt+1.
  - div is compared live. Lowering div below cnt causes a slot on the next cycle. div=0 gives a slot every cycle.
  - After enable rises, the first slot occurs at the (div+1)th enabled cycle.
- Arbitration (combinational, only in a slot cycle):
  - One valid requester: it wins.
  - Both valid, mode=1: requester 0 wins.
  - Both valid, mode=0: the requester != last_grant wins.
  - reqN_ready = slot & win_N. Ready is never asserted outside a slot; at most one ready per cycle.
- Handshake:
  - Transfer when reqN_valid & reqN_ready.
  - Requesters must hold valid and data stable until ready. Ready may depend on valid; valid must not depend on ready.
- Transfer in cycle T produces, at T+1:
  - dac_d = winner data;
  - dac_upd = 1 for exactly one cycle;
  - grant_id = winner;
  - last_grant <= winner (updated in both modes).
- Empty slot (slot with no valid): dac_d and grant_id hold, dac_upd=0, underrun_cnt increments and saturates at 255. A write of the same code still pulses dac_upd.
- Outside slots: dac_upd=0 and all registers hold.
- mode changes take effect at the next slot. last_grant is not cleared on a mode change.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both valid high -> dac_d=0x200, dac_upd=0, grant_id=0, underrun_cnt=0, both ready=0 throughout.
- Pacing: div=3, enable=1, req0 streams 0x001, 0x002, 0x003 -> req0_ready high in cycles 4, 8, 12 after enable; dac_d=0x001/0x002/0x003 with dac_upd pulses in cycles 5, 9, 13.
- Round-robin: div=1, mode=0, both valid continuously (req0=0x111, req1=0x222) -> grant_id sequence 0,1,0,1; dac_d alternates 0x111/0x222. Switch to mode=1 -> grant_id stays 0.
- Underrun: div=0, enable=1, no valid for 300 cycles -> underrun_cnt=255 (saturated), dac_d holds last code, dac_upd never pulses.
- Enable/div edges: div=5, drop enable at cnt=3 -> no ready/upd while low. Re-enable with div=2 -> first slot on the 3rd enabled cycle. With cnt=4, lower div from 7 to 2 -> slot next cycle.
- Reset mid-operation: req1 valid and slot imminent, assert reset=0 -> no ready, dac_d=0x200 at next edge. After release, the first conflict grants requester 0.
